logcap_cmd_initiator: RTL

Hub-side initiator for the logic-capture peripheral's command/register protocol. It accepts one command request at a time from the host-facing hub logic and drives the peripheral's 64-bit register input and command strobe. It then waits for the peripheral's sticky acknowledge, captures the 64-bit register output, clears the acknowledge with `CMD_ACK` and returns one response per transfer. `CMD_READ_TRACE_DATA` is handled as a multi-word burst.

---
 rtl/logcap_cmd_pkg.sv | 54 +++++
 rtl/logcap_cmd_initiator_timer.sv | 30 +++
 rtl/logcap_cmd_initiator.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/logcap_cmd_pkg.sv
// Shared definitions for the logic-capture command/register protocol:
// command codes, status bit positions, initiator states and helpers.
package logcap_cmd_pkg;

  localparam logic [7:0] CMD_NOP              = 8'h00;
  localparam logic [7:0] CMD_START            = 8'h01;
  localparam logic [7:0] CMD_ABORT            = 8'h02;
  localparam logic [7:0] CMD_TRIG_CFG         = 8'h03;
  localparam logic [7:0] CMD_BUF_CFG          = 8'h04;
  localparam logic [7:0] CMD_READ_TRACE_DATA  = 8'h05;
  localparam logic [7:0] CMD_READ_TRACE_SIZE  = 8'h06;
  localparam logic [7:0] CMD_READ_TRIG_SAMPLE = 8'h07;
  localparam logic [7:0] CMD_ACK              = 8'h08;
  localparam logic [7:0] CMD_RESET            = 8'h09;
  localparam logic [7:0] CMD_READ_BUFF_CFG    = 8'h0A;
  localparam logic [7:0] CMD_READ_TRIG_CFG    = 8'h0B;

  localparam int ST_IDLE_BIT = 0;
  localparam int ST_PRE_BIT  = 1;
  localparam int ST_POST_BIT = 2;
  localparam int ST_ACK_BIT  = 3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 65535;
  localparam int TIMEOUT_W              = $clog2(DEFAULT_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_PRECLR      = 3'd1,
    S_PRECLR_WAIT = 3'd2,
    S_ISSUE       = 3'd3,
    S_WAIT_ACK    = 3'd4,
    S_CLEAR       = 3'd5,
    S_WAIT_CLR    = 3'd6,
    S_RESP        = 3'd7
  } state_t;

  function automatic int tmo_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction

  function automatic logic cmd_is_rejected(input logic [7:0] cmd);
    return (cmd == CMD_NOP) || (cmd == CMD_ACK) || (cmd > CMD_READ_TRIG_CFG);
  endfunction

  // Trace-data reads are bursts of N words; a zero count still returns one word.
  function automatic logic [31:0] burst_words(input logic [7:0] cmd, input logic [63:0] wdata);
    if ((cmd == CMD_READ_TRACE_DATA) && (wdata[31:0] != 32'd0)) begin
      return wdata[31:0];
    end else begin
      return 32'd1;
    end
  endfunction

endpackage

// File: rtl/logcap_cmd_initiator_timer.sv
// Clear-on-enter saturating wait counter; o_expired is high once the
// count has reached TIMEOUT_CYCLES and stays high until cleared.
module cmd_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int W              = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [W-1:0] r_count;

  assign o_expired = (r_count == W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + W'(1);
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/logcap_cmd_initiator.sv
// Hub-side initiator: issues one peripheral command per request, waits for the
// sticky ack, captures regOut, clears the ack and returns one response per word.
module logcap_cmd_initiator
  import logcap_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_cmd,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_data,
  output logic        resp_err,
  output logic        resp_last,
  output logic [63:0] periph_regin,
  input  logic [63:0] periph_regout,
  output logic [7:0]  command,
  output logic        command_strobe,
  input  logic [7:0]  status,
  output logic [7:0]  status_q
);

  localparam int W_TMO = tmo_width(TIMEOUT_CYCLES);

  state_t      r_state, w_state_next;
  logic [7:0]  r_cmd;
  logic [31:0] r_words_left, w_words_next;
  logic        r_req_ready, r_resp_valid, r_resp_err, r_resp_last;
  logic [63:0] r_resp_data, r_regin;
  logic [7:0]  r_command, r_status_q, w_command_next;
  logic        r_strobe, w_strobe_next;
  logic        w_ack, w_accept, w_handshake, w_err_next;
  logic        w_timer_en, w_timer_clr, w_expired;

  assign w_ack       = status[ST_ACK_BIT];
  assign w_accept    = (r_state == S_IDLE) && r_req_ready && req_valid;
  assign w_handshake = r_resp_valid && resp_ready;
  assign w_timer_clr = (w_state_next != r_state);

  cmd_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .W             (W_TMO)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timer_clr),
    .i_enable (w_timer_en),
    .o_expired(w_expired)
  );

  // Next-state, error and word-count decisions; ack wins over a same-cycle timeout.
  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_resp_err;
    w_words_next = r_words_left;
    w_timer_en   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_err_next   = cmd_is_rejected(req_cmd);
          w_words_next = burst_words(req_cmd, req_wdata);
          if (cmd_is_rejected(req_cmd)) begin
            w_state_next = S_RESP;
          end else if (w_ack) begin
            w_state_next = S_PRECLR;
          end else begin
            w_state_next = S_ISSUE;
          end
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_PRECLR: w_state_next = S_PRECLR_WAIT;
      S_PRECLR_WAIT: begin
        w_timer_en = 1'b1;
        if (!w_ack) begin
          w_state_next = S_ISSUE;
        end else if (w_expired) begin
          w_state_next = S_RESP;
          w_err_next   = 1'b1;
        end else begin
          w_state_next = S_PRECLR_WAIT;
        end
      end
      S_ISSUE: w_state_next = S_WAIT_ACK;
      S_WAIT_ACK: begin
        w_timer_en = 1'b1;
        if (w_ack) begin
          w_state_next = S_CLEAR;
        end else if (w_expired) begin
          w_state_next = S_RESP;
          w_err_next   = 1'b1;
        end else begin
          w_state_next = S_WAIT_ACK;
        end
      end
      S_CLEAR: w_state_next = S_WAIT_CLR;
      S_WAIT_CLR: begin
        w_timer_en = 1'b1;
        if (!w_ack) begin
          w_state_next = S_RESP;
        end else if (w_expired) begin
          w_state_next = S_RESP;
          w_err_next   = 1'b1;
        end else begin
          w_state_next = S_WAIT_CLR;
        end
      end
      S_RESP: begin
        if (w_handshake && r_resp_last) begin
          w_state_next = S_IDLE;
          w_err_next   = 1'b0;
        end else if (w_handshake) begin
          // The peripheral reloads and re-acks after each clear, so no new strobe.
          w_state_next = S_WAIT_ACK;
          w_words_next = r_words_left - 32'd1;
        end else begin
          w_state_next = S_RESP;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobe is decoded from the next state so it is registered yet aligned with it.
  always_comb begin
    w_strobe_next  = 1'b0;
    w_command_next = 8'h00;
    case (w_state_next)
      S_PRECLR, S_CLEAR: begin
        w_strobe_next  = 1'b1;
        w_command_next = CMD_ACK;
      end
      S_ISSUE: begin
        w_strobe_next  = 1'b1;
        w_command_next = w_accept ? req_cmd : r_cmd;
      end
      default: begin
        w_strobe_next  = 1'b0;
        w_command_next = 8'h00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd        <= 8'h00;
      r_words_left <= 32'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_last  <= 1'b0;
      r_resp_data  <= 64'd0;
      r_regin      <= 64'd0;
      r_command    <= 8'h00;
      r_strobe     <= 1'b0;
      r_status_q   <= 8'h00;
    end else begin
      r_state      <= w_state_next;
      r_words_left <= w_words_next;
      r_req_ready  <= (w_state_next == S_IDLE);
      r_resp_valid <= (w_state_next == S_RESP);
      r_resp_err   <= w_err_next;
      r_resp_last  <= (w_state_next == S_RESP) && (w_err_next || (w_words_next == 32'd1));
      r_command    <= w_command_next;
      r_strobe     <= w_strobe_next;
      r_status_q   <= status;
      if (w_accept) begin
        r_cmd   <= req_cmd;
        r_regin <= req_wdata;
      end else begin
        r_cmd   <= r_cmd;
        r_regin <= r_regin;
      end
      if (w_accept) begin
        r_resp_data <= 64'd0;
      end else if ((r_state == S_WAIT_ACK) && w_ack) begin
        r_resp_data <= periph_regout;
      end else if ((r_state == S_WAIT_ACK) && w_expired) begin
        r_resp_data <= 64'd0;
      end else begin
        r_resp_data <= r_resp_data;
      end
    end
  end

  assign req_ready      = r_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_data      = r_resp_data;
  assign resp_err       = r_resp_err;
  assign resp_last      = r_resp_last;
  assign periph_regin   = r_regin;
  assign command        = r_command;
  assign command_strobe = r_strobe;
  assign status_q       = r_status_q;

endmodule
